// File: rtl/cmp_unit_pipe.sv
// cmp_unit_pipe: two-stage pipelined compare unit for the ALU.
// Compares A and B (signed or unsigned per transaction), returns compare
// codes or MAX/MIN, with valid/ready handshakes on both sides and a
// saturating count of delivered true compare results.
module cmp_unit_pipe #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 2 * WIDTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic [2:0]           ALU_FUN,
  input  logic                 SIGNED,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] CMP_OUT,
  output logic                 CMP_Flag,
  output logic [2:0]           CMP_STAT,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] TRUE_CNT
);

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_EQ  = 3'b001,
    OP_GT  = 3'b010,
    OP_LT  = 3'b011,
    OP_NE  = 3'b100,
    OP_GE  = 3'b101,
    OP_MAX = 3'b110,
    OP_MIN = 3'b111
  } op_e;

  // Widen an operand to the result width, replicating the sign bit when signed.
  function automatic logic [OUT_WIDTH-1:0] extend(input logic [WIDTH-1:0] v,
                                                  input logic             sg);
    logic [OUT_WIDTH-1:0] r;
    r            = {OUT_WIDTH{sg & v[WIDTH-1]}};
    r[WIDTH-1:0] = v;
    return r;
  endfunction

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  op_e              s1_op;
  logic             s1_signed;
  logic             s1_eq;
  logic             s1_gt;
  logic             s1_lt;

  // Stage 2 side state: whether the held result counts as a true compare
  logic             s2_true;

  // Handshake terms
  logic s2_consume;
  logic s1_advance;
  logic in_fire;

  // Combinational compare of the incoming operands
  logic in_eq;
  logic in_gt;
  logic in_lt;

  // Stage 2 next-result terms
  logic [OUT_WIDTH-1:0] res_value;
  logic [2:0]           res_stat;
  logic                 res_true;

  // S2 frees up when consumed; S1 moves on when S2 is empty or freeing up.
  assign s2_consume = CMP_Flag & out_ready;
  assign s1_advance = s1_valid & (~CMP_Flag | out_ready);
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  // Compare flags for the operands presented this cycle; SIGNED never affects eq.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    in_eq = (A == B);
    in_gt = 1'b0;
    if (SIGNED) begin
      in_gt = ($signed(A) > $signed(B));
    end else begin
      in_gt = (A > B);
    end
    in_lt = ~in_eq & ~in_gt;
  end

  // Stage 1: capture operands, operation and compare flags on input transfer.
  always_ff @(posedge clk or negedge RST) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (!RST) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_NOP;
      s1_signed <= 1'b0;
      s1_eq     <= 1'b0;
      s1_gt     <= 1'b0;
      s1_lt     <= 1'b0;
    end else if (in_fire) begin
      s1_valid  <= 1'b1;
      s1_a      <= A;
      s1_b      <= B;
      s1_op     <= op_e'(ALU_FUN);
      s1_signed <= SIGNED;
      s1_eq     <= in_eq;
      s1_gt     <= in_gt;
      s1_lt     <= in_lt;
    end else if (s1_advance) begin
      s1_valid  <= 1'b0;
    end
  end

  // Form the stage-2 result from the registered stage-1 flags.
  always_comb begin
    res_true  = 1'b0;
    res_value = '0;
    res_stat  = {s1_lt, s1_gt, s1_eq};
    unique case (s1_op)
      OP_NOP: res_stat  = 3'b000;
      OP_EQ:  res_true  = s1_eq;
      OP_GT:  res_true  = s1_gt;
      OP_LT:  res_true  = s1_lt;
      OP_NE:  res_true  = ~s1_eq;
      OP_GE:  res_true  = s1_gt | s1_eq;
      OP_MAX: res_value = extend(s1_gt ? s1_a : s1_b, s1_signed);
      OP_MIN: res_value = extend(s1_lt ? s1_a : s1_b, s1_signed);
      default: res_true = 1'b0;
    endcase
    if (res_true) begin
      res_value = OUT_WIDTH'(s1_op);
    end
  end

  // Stage 2: load on S1 advance, hold under backpressure, drop valid once consumed.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      CMP_Flag <= 1'b0;
      CMP_OUT  <= '0;
      CMP_STAT <= 3'b000;
      s2_true  <= 1'b0;
    end else if (s1_advance) begin
      CMP_Flag <= 1'b1;
      CMP_OUT  <= res_value;
      CMP_STAT <= res_stat;
      s2_true  <= res_true;
    end else if (s2_consume) begin
      CMP_Flag <= 1'b0;
    end
  end

  // Saturating count of consumed true compare results; clear has priority.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      TRUE_CNT <= '0;
    end else if (cnt_clr) begin
      TRUE_CNT <= '0;
    end else if (s2_consume && s2_true && (TRUE_CNT != '1)) begin
      TRUE_CNT <= TRUE_CNT + CNT_WIDTH'(1);
    end
  end

endmodule
